// File: rtl/prcoder_pkg.sv
// Shared types for the priority encoder/decoder pair.
// Provides default widths, decoder FSM states and the code type.
package prcoder_pkg;

    localparam int W_DEF  = 8;
    localparam int CW_DEF = $clog2(W_DEF);

    typedef enum logic {
        ACCUM,
        HOLD
    } prdec_state_t;

    typedef logic [CW_DEF-1:0] prcode_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder with enable.
// Ports: code (bit index), en (gate), onehot (W-bit, zero when en=0).
module onehot_dec #(
    parameter int W  = 8,
    localparam int CW = $clog2(W)
) (
    input  logic [CW-1:0] code,
    input  logic          en,
    output logic [W-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/prdecoder_acc.sv
// Accumulating priority decoder: rebuilds a request vector from a
// stream of descending priority codes and flags ordering violations.
// Ports: clk, rst (sync, active-high); input beat stream
// in_valid/in_ready/in_code/in_none/in_last; output vector
// out_valid/out_ready/out_vec/out_err.
module prdecoder_acc
    import prcoder_pkg::*;
#(
    parameter int W  = W_DEF,
    localparam int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_code,
    input  logic          in_none,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_vec,
    output logic          out_err
);

    prdec_state_t  state, state_d;
    logic [W-1:0]  acc, acc_d;
    logic          err_acc, err_d;
    logic [CW-1:0] prev_code, prev_d;
    logic          first, first_d;
    logic [W-1:0]  vec_d;
    logic          oerr_d;
    logic [W-1:0]  dec;
    logic          beat_err;

    onehot_dec #(.W(W)) u_dec (
        .code   (in_code),
        .en     (in_valid & ~in_none),
        .onehot (dec)
    );

    // Handshake flags come straight from the registered state, so there
    // is no combinational path from out_ready to in_ready.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);

    always_comb begin
        state_d  = state;
        acc_d    = acc;
        err_d    = err_acc;
        prev_d   = prev_code;
        first_d  = first;
        vec_d    = out_vec;
        oerr_d   = out_err;
        beat_err = 1'b0;
        unique case (state)
            ACCUM: begin
                if (in_valid) begin
                    // An empty-vector beat must stand alone; a real code
                    // must be strictly below the previous real code.
                    if (in_none) begin
                        beat_err = !first || !in_last;
                    end else begin
                        beat_err = !first && (in_code >= prev_code);
                        prev_d   = in_code;
                        first_d  = 1'b0;
                    end
                    acc_d = acc | dec;
                    err_d = err_acc | beat_err;
                    if (in_last) begin
                        state_d = HOLD;
                        vec_d   = acc_d;
                        oerr_d  = err_d;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    first_d = 1'b1;
                    prev_d  = '1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            err_acc   <= 1'b0;
            prev_code <= '1;
            first     <= 1'b1;
            out_vec   <= '0;
            out_err   <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            err_acc   <= err_d;
            prev_code <= prev_d;
            first     <= first_d;
            out_vec   <= vec_d;
            out_err   <= oerr_d;
        end
    end

endmodule

// File: tb/tb_prdecoder_acc.sv
// Self-checking bench for prdecoder_acc: directed cases followed by
// random vectors compared against a list-based reference model.
module tb_prdecoder_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       in_none;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_vec;
    logic       out_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prdecoder_acc #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_none   (in_none),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_err   (out_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic beat(input int c, input bit none, input bit last);
        bit took;
        int budget;
        in_valid = 1'b1;
        in_code  = 3'(c);
        in_none  = none;
        in_last  = last;
        took     = 1'b0;
        budget   = 0;
        while (!took && budget < 20) begin
            took = in_ready;
            step();
            budget++;
        end
        if (!took) chk("beat_accept_timeout", 32'(took), 32'd1);
        in_valid = 1'b0;
        in_code  = 3'($urandom_range(0, 7));
        in_none  = 1'($urandom_range(0, 1));
        in_last  = 1'($urandom_range(0, 1));
    endtask

    // Called right after the last beat: output must already be valid,
    // stay stable for 'hold' cycles, then drain in one handshake.
    task automatic take(input string tag, input logic [7:0] ev,
                        input bit ee, input int hold);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_vec"}, 32'(out_vec), 32'(ev));
        chk({tag, "_err"}, 32'(out_err), 32'(ee));
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_vec"}, 32'(out_vec), 32'(ev));
            chk({tag, "_hold_err"}, 32'(out_err), 32'(ee));
            chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_drain_rdy"}, 32'(in_ready), 32'd1);
    endtask

    // Reference: OR of the listed codes; error if a real code is not
    // strictly below the preceding real code, or if an empty beat is
    // not a vector by itself (only last beat, no real code before it).
    task automatic model(input int c[$], input bit nn[$],
                         output logic [7:0] v, output bit e);
        bit seen;
        int pv;
        v    = '0;
        e    = 1'b0;
        seen = 1'b0;
        pv   = 0;
        for (int i = 0; i < c.size(); i++) begin
            if (nn[i]) begin
                if (seen || i != c.size() - 1) e = 1'b1;
            end else begin
                if (seen && c[i] >= pv) e = 1'b1;
                v    = v | (8'd1 << c[i]);
                pv   = c[i];
                seen = 1'b1;
            end
        end
    endtask

    task automatic send(input int c[$], input bit nn[$], input int gmax);
        for (int i = 0; i < c.size(); i++) begin
            int g;
            g = $urandom_range(0, gmax);
            for (int k = 0; k < g; k++) step();
            beat(c[i], nn[i], i == c.size() - 1);
            if (i != c.size() - 1)
                chk("mid_valid", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        int         c[$];
        bit         nn[$];
        logic [7:0] ev;
        bit         ee;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        in_none   = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_vec", 32'(out_vec), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);

        beat(5, 0, 1);
        take("single5", 8'b0010_0000, 0, 0);

        beat(7, 0, 0);
        beat(4, 0, 0);
        beat(1, 0, 0);
        beat(0, 0, 1);
        take("desc7410", 8'b1001_0011, 0, 3);

        beat(0, 1, 1);
        take("none", 8'h00, 0, 1);
        beat(0, 0, 1);
        take("code0", 8'h01, 0, 0);

        beat(3, 0, 0);
        beat(6, 0, 1);
        take("ascend", 8'b0100_1000, 1, 1);
        beat(2, 0, 0);
        beat(2, 0, 1);
        take("dup", 8'h04, 1, 0);
        beat(1, 0, 1);
        take("errclr", 8'h02, 0, 0);

        beat(0, 1, 0);
        beat(4, 0, 1);
        take("none_notlast", 8'h10, 1, 0);
        beat(5, 0, 0);
        beat(0, 1, 1);
        take("none_after", 8'h20, 1, 0);

        beat(6, 0, 0);
        beat(5, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        step();
        chk("midrst_valid2", 32'(out_valid), 32'd0);
        beat(0, 0, 1);
        take("postrst", 8'h01, 0, 0);

        step();
        beat(7, 0, 0);
        step();
        step();
        beat(3, 0, 1);
        chk("gap_valid", 32'(out_valid), 32'd1);
        chk("gap_vec", 32'(out_vec), 32'h88);

        in_valid = 1'b1;
        in_code  = 3'd2;
        in_none  = 1'b0;
        in_last  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("hold_block_rdy", 32'(in_ready), 32'd0);
            step();
            chk("hold_block_vec", 32'(out_vec), 32'h88);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold_back_rdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        take("held_beat", 8'h04, 0, 0);

        for (int v = 0; v < 40; v++) begin
            int n;
            int mode;
            int cur;
            c.delete();
            nn.delete();
            mode = $urandom_range(0, 3);
            n    = $urandom_range(1, 10);
            if (mode == 2) begin
                c.push_back(0);
                nn.push_back(1'b1);
            end else begin
                cur = 8;
                for (int i = 0; i < n; i++) begin
                    if (mode == 0) begin
                        cur = cur - $urandom_range(1, 2);
                        if (cur < 0) break;
                        c.push_back(cur);
                    end else begin
                        c.push_back($urandom_range(0, 7));
                    end
                    nn.push_back(mode == 3 && $urandom_range(0, 4) == 0);
                end
            end
            model(c, nn, ev, ee);
            send(c, nn, 2);
            take("rand", ev, ee, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prdecoder_acc.md
Name: prdecoder_acc

Overview:
- Accumulating priority decoder; the receive-side inverse of the 8-to-3 priority encoder.
- Accepts a stream of 3-bit priority codes, highest first, one per beat, over a valid/ready handshake.
- Decodes each code to one-hot and ORs it into an accumulator. On the beat flagged last, presents the rebuilt request vector with an ordering-error flag.
- Sits downstream of the encoder in the arbitration/request-forwarding path.

Parameters:
- W, 8, request vector width; power of two, >= 2.
- CW, $clog2(W), code width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  code beat present.
- in_ready  out  1  block can accept a beat.
- in_code  in  CW  priority code (bit index of a set request).
- in_none  in  1  beat encodes the empty vector (disambiguates code 0 vs no request).
- in_last  in  1  final beat of the current vector.
- out_valid  out  1  rebuilt vector available.
- out_ready  in  1  consumer accepts the vector.
- out_vec  out  W  rebuilt request vector.
- out_err  out  1  sequence violation seen in this vector.

Behaviour:
- Reset, synchronous and active-high, sampled on clk rising edge:
  - state=ACCUM; in_ready=1; out_valid=0; out_vec=0; out_err=0.
  - accumulator=0; prev_code=all-ones; first=1.
  - Reset mid-vector discards partial accumulation and any held output; no output is produced.
- Beat accepted when in_valid & in_ready.
- State ACCUM (in_ready=1, out_valid=0):
  - Accepted beat, in_none=0: acc |= onehot(in_code).
    - If first=0 and in_code >= prev_code (not strictly descending, including duplicates): err_acc <= 1.
    - prev_code <= in_code; first <= 0.
  - Accepted beat, in_none=1: acc unchanged.
    - If first=0 or in_last=0: err_acc <= 1. in_none is legal only as a single-beat vector.
  - Accepted beat with in_last=1: next cycle state=HOLD; out_vec=final acc including this beat; out_err=final err_acc; out_valid=1.
  - Latency: out_valid is asserted exactly 1 cycle after the last beat is accepted.
- State HOLD (in_ready=0, out_valid=1):
  - out_vec and out_err are stable while out_valid & !out_ready.
  - On out_valid & out_ready: next cycle state=ACCUM; out_valid=0; acc=0; err_acc=0; first=1; prev_code=all-ones.
  - out_vec keeps its last value after handoff; it is a don't-care while out_valid=0.
- Throughput: a vector of N beats takes N+1 cycles minimum. No overlap between HOLD and ACCUM; in_ready is registered-state-derived only, with no combinational path from out_ready.
- in_code values are all in range because W is a power of two; no range check is needed.
- More than W beats in a vector necessarily violates ordering and is flagged via the descending check.
- Inputs are ignored while in_valid=0; in_code, in_none and in_last are don't-care then.

Decomposition:
- Shared package prcoder_pkg:
  - localparam W_DEF=8 and CW_DEF=$clog2(W_DEF).
  - typedef enum logic {ACCUM, HOLD} prdec_state_t.
  - typedef logic [CW_DEF-1:0] prcode_t.
- One sub-module, onehot_dec: combinational, parameter W, input [CW-1:0] code, input en, output [W-1:0] onehot. Output is 0 when en=0. Reusable by other consumers of the encoder.

Test Plan:
- Reset then single beat code=3'd5, last=1 -> 1 cycle later out_valid=1, out_vec=8'b0010_0000, out_err=0; with out_ready=1, out_valid=0 the next cycle and in_ready=1.
- Beats 7,4,1,0 (last on 0), out_ready held 0 for 3 cycles -> out_vec=8'b1001_0011, out_err=0, held stable all 3 cycles; in_ready=0 throughout HOLD.
- Single beat in_none=1, last=1 -> out_vec=8'h00, out_err=0. Separately, single beat code=0, none=0 -> out_vec=8'h01, out_err=0.
- Ordering faults:
  - Beats 3,6 (last) -> out_vec=8'b0100_1000, out_err=1.
  - Beats 2,2 (last) -> out_vec=8'h04, out_err=1.
  - Next vector, beat 1 last -> out_err=0 (error flag cleared).
- Beats 6,5 then rst=1 for one cycle before last -> out_valid stays 0; after reset, beat 0 last -> out_vec=8'h01 (no stale bits).
- in_valid toggling with gaps between beats 7,3 (last) -> out_vec=8'h88. A beat presented during HOLD is not accepted (in_ready=0) and is accepted once back in ACCUM.
